// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and synchronizer depth for the debouncer
package debounce_pkg;

  // Two-bit encoding: bit 1 is the accepted level, bit 0 flags a pending change.
  typedef enum logic [1:0] {
    S_LOW     = 2'b00,
    S_WAIT_HI = 2'b01,
    S_HIGH    = 2'b10,
    S_WAIT_LO = 2'b11
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_fsm_if.sv
// rtl/debounce_fsm_if.sv - sample tick, raw input and debounced outputs of one debouncer
interface debounce_fsm_if;

  logic tick;
  logic din;
  logic level;
  logic rise;
  logic fall;

  // Driver side: prescaler tick plus raw button, observes the clean outputs.
  modport master (
    output tick,
    output din,
    input  level,
    input  rise,
    input  fall
  );

  // Debouncer side.
  modport slave (
    input  tick,
    input  din,
    output level,
    output rise,
    output fall
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - flop-chain synchronizer for one asynchronous input, resets to 0
module sync_2ff
  import debounce_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through the chain every clock; first stage may go metastable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// rtl/debounce_fsm.sv - tick-sampled debouncer; DEBOUNCE_EDGE_PULSE_EN enables rise/fall pulses
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int STABLE = 4
) (
  input  logic           clk,
  input  logic           rst,
  debounce_fsm_if.slave  bus
);

  localparam int CW = $clog2(STABLE);
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic          w_ds;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          w_level_nxt;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic          r_rise;
  logic          r_fall;
  logic          w_rise_nxt;
  logic          w_fall_nxt;
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (bus.din),
    .o_q (w_ds)
  );

  // Next state: only a tick moves the FSM; cnt holds the number of agreeing samples so far.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
`endif
    if (bus.tick) begin
      case (r_state)
        S_LOW: begin
          if (w_ds) begin
            w_state_nxt = S_WAIT_HI;
            w_cnt_nxt   = CW'(1);
          end
        end
        S_WAIT_HI: begin
          if (!w_ds) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LAST) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            w_rise_nxt  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (!w_ds) begin
            w_state_nxt = S_WAIT_LO;
            w_cnt_nxt   = CW'(1);
          end
        end
        S_WAIT_LO: begin
          if (w_ds) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LAST) begin
            w_state_nxt = S_LOW;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            w_fall_nxt  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and clean level register; reset discards any pending wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  // Edge pulses are registered so they line up with the level change and last one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign bus.rise = r_rise;
  assign bus.fall = r_fall;
`else
  assign bus.rise = 1'b0;
  assign bus.fall = 1'b0;
`endif

  assign bus.level = r_level;

endmodule

// File: tb/tb_debounce_fsm.sv
// tb/tb_debounce_fsm.sv - scoreboard bench for debounce_fsm with a mod-N tick prescaler
module tb_debounce_fsm;

  localparam int STABLE = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   presc_n = 10;
  int   pcnt = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;

  logic [2:0] exp_q[$];
  logic [2:0] chk_exp;
  logic       m_s1, m_s2, m_level;
  int         m_run;

  always #5 clk = ~clk;

  debounce_fsm_if bus();

  debounce_fsm #(.STABLE(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Prescaler: one-clock tick every presc_n clocks, continuous when presc_n is 1.
  always @(negedge clk) begin
    if (presc_n <= 1) begin
      pcnt = 0;
      bus.tick = 1'b1;
    end else if (pcnt == presc_n - 1) begin
      pcnt = 0;
      bus.tick = 1'b1;
    end else begin
      pcnt = pcnt + 1;
      bus.tick = 1'b0;
    end
  end

  // Reference model: counts consecutive samples that disagree with the accepted level.
  always @(posedge clk or negedge rst) begin
    logic pr, pf;
    pr = 1'b0;
    pf = 1'b0;
    if (!rst) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_level = 1'b0;
      m_run = 0;
    end else begin
      if (bus.tick === 1'b1) begin
        if (m_s2 != m_level) begin
          m_run = m_run + 1;
          if (m_run == STABLE) begin
            pr = !m_level;
            pf = m_level;
            m_level = !m_level;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.din;
      exp_q.push_back({m_level, pr & PULSE_EN, pf & PULSE_EN});
    end
  end

  // Scoreboard drain: every clock out of reset must match the model exactly.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk_exp = exp_q.pop_front();
      if (rst) begin
        vectors = vectors + 1;
        if ({bus.level, bus.rise, bus.fall} !== chk_exp) begin
          miscompares = miscompares + 1;
          $display("FAIL scoreboard t=%0t level/rise/fall got %b expected %b",
                   $time, {bus.level, bus.rise, bus.fall}, chk_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (bus.rise) rise_cnt = rise_cnt + 1;
      if (bus.fall) fall_cnt = fall_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      int g;
      g = 0;
      do begin
        @(posedge clk);
        g = g + 1;
      end while (bus.tick !== 1'b1 && g < 64);
      if (bus.tick !== 1'b1) begin
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL tick_timeout: no tick within 64 clocks");
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.rise, bus.fall} !== 3'b000) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_state got %b expected 000", {bus.level, bus.rise, bus.fall});
    end
    #1 rst = 1'b1;
    wait_ticks(1);
    #1 bus.din = 1'b1;
    wait_ticks(STABLE + 1);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL pre_reset_level got %b expected 1", bus.level);
    end
    #1 rst = 1'b0;
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.rise, bus.fall} !== 3'b000) begin
      miscompares = miscompares + 1;
      $display("FAIL async_reset got %b expected 000", {bus.level, bus.rise, bus.fall});
    end
    bus.din = 1'b0;
    #3 rst = 1'b1;
    wait_ticks(2);
  endtask

  task automatic test_clean_press();
    int r0, f0;
    wait_ticks(1);
    #1 bus.din = 1'b1;
    r0 = rise_cnt;
    f0 = fall_cnt;
    wait_ticks(STABLE - 1);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL press_early got level %b expected 0", bus.level);
    end
    wait_ticks(1);
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.rise} !== {1'b1, PULSE_EN}) begin
      miscompares = miscompares + 1;
      $display("FAIL press_accept got level/rise %b expected %b", {bus.level, bus.rise}, {1'b1, PULSE_EN});
    end
    wait_ticks(6);
    vectors = vectors + 1;
    if (rise_cnt - r0 !== int'(PULSE_EN) || fall_cnt - f0 !== 0) begin
      miscompares = miscompares + 1;
      $display("FAIL press_single_rise got rises %0d falls %0d expected %0d 0", rise_cnt - r0, fall_cnt - f0, PULSE_EN);
    end
    #1 bus.din = 1'b0;
    f0 = fall_cnt;
    wait_ticks(STABLE - 1);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL release_early got level %b expected 1", bus.level);
    end
    wait_ticks(1);
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.fall, bus.rise} !== {1'b0, PULSE_EN, 1'b0}) begin
      miscompares = miscompares + 1;
      $display("FAIL release_accept got level/fall/rise %b expected %b", {bus.level, bus.fall, bus.rise}, {1'b0, PULSE_EN, 1'b0});
    end
    wait_ticks(4);
    vectors = vectors + 1;
    if (fall_cnt - f0 !== int'(PULSE_EN)) begin
      miscompares = miscompares + 1;
      $display("FAIL release_single_fall got %0d expected %0d", fall_cnt - f0, PULSE_EN);
    end
  endtask

  task automatic test_bounce();
    int r0;
    r0 = rise_cnt;
    wait_ticks(1);
    #1 bus.din = 1'b1;
    wait_ticks(1);
    #1 bus.din = 1'b0;
    wait_ticks(1);
    #1 bus.din = 1'b1;
    wait_ticks(1);
    wait_ticks(STABLE - 2);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL bounce_hold got level %b expected 0", bus.level);
    end
    wait_ticks(1);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL bounce_accept got level %b expected 1", bus.level);
    end
    wait_ticks(4);
    vectors = vectors + 1;
    if (rise_cnt - r0 !== int'(PULSE_EN)) begin
      miscompares = miscompares + 1;
      $display("FAIL bounce_rise_count got %0d expected %0d", rise_cnt - r0, PULSE_EN);
    end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = fall_cnt;
    #1 bus.din = 1'b0;
    wait_ticks(STABLE - 1);
    #1 bus.din = 1'b1;
    wait_ticks(6);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b1 || fall_cnt != f0) begin
      miscompares = miscompares + 1;
      $display("FAIL glitch_ignored got level %b falls %0d expected 1 0", bus.level, fall_cnt - f0);
    end
    bus.din = 1'b0;
    wait_ticks(STABLE + 2);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL glitch_release got level %b expected 0", bus.level);
    end
  endtask

  task automatic test_reset_mid_wait();
    int r0;
    wait_ticks(1);
    #1 bus.din = 1'b1;
    wait_ticks(STABLE - 1);
    #1 rst = 1'b0;
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.rise} !== 2'b00) begin
      miscompares = miscompares + 1;
      $display("FAIL midwait_reset got level/rise %b expected 00", {bus.level, bus.rise});
    end
    #4 rst = 1'b1;
    r0 = rise_cnt;
    wait_ticks(STABLE - 1);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL midwait_discard got level %b expected 0", bus.level);
    end
    wait_ticks(1);
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.rise} !== {1'b1, PULSE_EN} || rise_cnt - r0 !== int'(PULSE_EN)) begin
      miscompares = miscompares + 1;
      $display("FAIL midwait_rise got level/rise %b count %0d expected %b %0d",
               {bus.level, bus.rise}, rise_cnt - r0, {1'b1, PULSE_EN}, PULSE_EN);
    end
    bus.din = 1'b0;
    wait_ticks(STABLE + 2);
  endtask

  task automatic test_back_to_back();
    int r0;
    presc_n = 1;
    @(negedge clk);
    @(posedge clk);
    #1 bus.din = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL n1_press_early got level %b expected 0", bus.level);
    end
    @(posedge clk);
    #1;
    vectors = vectors + 1;
    if ({bus.level, bus.rise} !== {1'b1, PULSE_EN}) begin
      miscompares = miscompares + 1;
      $display("FAIL n1_press_accept got level/rise %b expected %b", {bus.level, bus.rise}, {1'b1, PULSE_EN});
    end
    bus.din = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL n1_release got level %b expected 0", bus.level);
    end
    r0 = rise_cnt;
    bus.din = 1'b1;
    repeat (STABLE - 1) @(posedge clk);
    #1 bus.din = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vectors = vectors + 1;
    if (bus.level !== 1'b0 || rise_cnt != r0) begin
      miscompares = miscompares + 1;
      $display("FAIL n1_short_pulse got level %b rises %0d expected 0 0", bus.level, rise_cnt - r0);
    end
    presc_n = 10;
    wait_ticks(2);
  endtask

  initial begin
    bus.din = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid_wait();
    test_back_to_back();
    test_clean_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
